// File: rtl/lat_ram_port.sv
// lat_ram_port: single-port RAM with a configurable command pipeline in
// front of the array and a configurable read-data pipeline behind it.
// Commands reach the array strictly in issue order, so a read always sees
// every earlier write. Reset flushes in-flight commands but leaves the
// array contents alone.
module lat_ram_port #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_DEPTH = 16,
  parameter int WRITE_LATENCY = 1,
  parameter int READ_LATENCY  = 1
) (
  input  logic                             i_clka,
  input  logic                             i_rsta,
  input  logic                             i_en,
  input  logic                             i_we,
  input  logic [$clog2(ADDRESS_DEPTH)-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]            i_din,
  output logic [DATA_WIDTH-1:0]            o_dout,
  output logic                             o_valid
);

  localparam int AW = $clog2(ADDRESS_DEPTH);

  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] din;
  } cmd_t;

  cmd_t in_cmd;
  cmd_t arr_cmd;

  assign in_cmd = '{en: i_en, we: i_we, addr: i_addr, din: i_din};

  // Command pipeline: WRITE_LATENCY-1 register stages, none at latency 1.
  generate
    if (WRITE_LATENCY == 1) begin : g_no_cpipe
      assign arr_cmd = in_cmd;
    end else begin : g_cpipe
      cmd_t cmd_pipe [1:WRITE_LATENCY-1];

      // Shift commands toward the array; reset only drops the enables, so
      // stale payload in an empty slot is harmless.
      always_ff @(posedge i_clka) begin
        if (i_rsta) begin
          for (int k = 1; k < WRITE_LATENCY; k++) cmd_pipe[k].en <= 1'b0;
        end else begin
          cmd_pipe[1] <= in_cmd;
          for (int k = 2; k < WRITE_LATENCY; k++) cmd_pipe[k] <= cmd_pipe[k-1];
        end
      end

      assign arr_cmd = cmd_pipe[WRITE_LATENCY-1];
    end
  endgenerate

  // Array-stage decode. Reset on the same edge cancels whatever is here,
  // which also covers a command presented alongside reset at latency 1.
  logic act, wr, rd;
  assign act = arr_cmd.en & ~i_rsta;
  assign wr  = act &  arr_cmd.we;
  assign rd  = act & ~arr_cmd.we;

  // Power-up contents are zero; reset never touches the array.
  logic [DATA_WIDTH-1:0] mem [ADDRESS_DEPTH] = '{default: '0};

  // Array write port.
  always_ff @(posedge i_clka) begin
    if (wr) mem[arr_cmd.addr] <= arr_cmd.din;
  end

  // Read-data pipeline: stage 1 captures the array, the last stage is the
  // output register. Data only advances with a valid bit so the output
  // holds the last read value across writes and idle slots.
  logic [READ_LATENCY:1]  vld_pipe;
  logic [DATA_WIDTH-1:0]  dat_pipe [1:READ_LATENCY];

  // Advance read results; reset clears valids and zeroes the data path.
  always_ff @(posedge i_clka) begin
    if (i_rsta) begin
      vld_pipe <= '0;
      for (int k = 1; k <= READ_LATENCY; k++) dat_pipe[k] <= '0;
    end else begin
      vld_pipe[1] <= rd;
      if (rd) dat_pipe[1] <= mem[arr_cmd.addr];
      for (int k = 2; k <= READ_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign o_valid = vld_pipe[READ_LATENCY];
  assign o_dout  = dat_pipe[READ_LATENCY];

endmodule
